// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle CPU control FSM with memory wait timeout, halt and fault handling
module multicycle_sequencer #(
  parameter int MemTimeout = 16,
  parameter int dataW = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ImemReady,
  input  logic             DmemReady,
  input  logic             RegWriteControl,
  input  logic             RAMRead,
  input  logic             RAMWriteControl,
  input  logic             TestBranch,
  input  logic             AlwaysBranch,
  input  logic             BranchTaken,
  input  logic             Halt,
  output logic             ImemReq,
  output logic             IRLoad,
  output logic             DmemReq,
  output logic             DmemWrite,
  output logic             RegWriteEn,
  output logic             PCWriteEn,
  output logic             PCSelBranch,
  output logic [2:0]       Stage,
  output logic             BusError,
  output logic [dataW-1:0] InstRetired
);
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2, MEM = 3'd3,
    WRITEBACK = 3'd4, HALTED = 3'd5, FAULT = 3'd7
  } stateT;
  localparam int cntW = $clog2(MemTimeout + 1);
  stateT state, nextState;
  logic [cntW-1:0] waitCnt;
  logic ready, timedOut, waiting;
  always_comb begin
    ready = (state == MEM) ? DmemReady : ImemReady;
    timedOut = !ready && (waitCnt == cntW'(MemTimeout - 1));
    waiting = (state == FETCH || state == MEM) && !ready;
    nextState = FAULT;
    unique case (state)
      FETCH:     nextState = ImemReady ? DECODE : timedOut ? FAULT : FETCH;
      DECODE:    nextState = EXECUTE;
      EXECUTE:   nextState = (RAMRead || RAMWriteControl) ? MEM : WRITEBACK;
      MEM:       nextState = DmemReady ? WRITEBACK : timedOut ? FAULT : MEM;
      WRITEBACK: nextState = Halt ? HALTED : FETCH;
      HALTED:    nextState = Halt ? HALTED : FETCH;
      default:   nextState = FAULT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      waitCnt <= '0;
      InstRetired <= '0;
    end else begin
      state <= nextState;
      waitCnt <= (waiting && nextState == state) ? waitCnt + cntW'(1) : '0;
      if (state == WRITEBACK) InstRetired <= InstRetired + dataW'(1);
    end
  end
  // strobes are forced low while reset is held, even before the state register clears
  assign ImemReq = !reset && state == FETCH;
  assign IRLoad = ImemReq && ImemReady;
  assign DmemReq = !reset && state == MEM;
  assign DmemWrite = DmemReq && RAMWriteControl;
  assign PCWriteEn = !reset && state == WRITEBACK;
  assign RegWriteEn = PCWriteEn && RegWriteControl;
  assign PCSelBranch = PCWriteEn && (AlwaysBranch || (TestBranch && BranchTaken));
  assign Stage = state;
  assign BusError = state == FAULT;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: table-driven instruction vectors plus directed halt, wrap, reset and timeout sequences
module tb_multicycle_sequencer;
  logic clk = 0;
  logic reset, ImemReady, DmemReady, RegWriteControl, RAMRead, RAMWriteControl;
  logic TestBranch, AlwaysBranch, BranchTaken, Halt;
  logic ImemReq, IRLoad, DmemReq, DmemWrite, RegWriteEn, PCWriteEn, PCSelBranch, BusError;
  logic [2:0] Stage;
  logic [3:0] InstRetired;
  logic [3:0] expRet;
  int nTests = 0, nFail = 0;

  always #5 clk = ~clk;

  multicycle_sequencer #(.MemTimeout(16), .dataW(4)) dut (
    .clk(clk), .reset(reset), .ImemReady(ImemReady), .DmemReady(DmemReady),
    .RegWriteControl(RegWriteControl), .RAMRead(RAMRead), .RAMWriteControl(RAMWriteControl),
    .TestBranch(TestBranch), .AlwaysBranch(AlwaysBranch), .BranchTaken(BranchTaken), .Halt(Halt),
    .ImemReq(ImemReq), .IRLoad(IRLoad), .DmemReq(DmemReq), .DmemWrite(DmemWrite),
    .RegWriteEn(RegWriteEn), .PCWriteEn(PCWriteEn), .PCSelBranch(PCSelBranch),
    .Stage(Stage), .BusError(BusError), .InstRetired(InstRetired)
  );

  typedef struct {
    logic regW, ramR, ramW, testB, alwaysB, taken;
    int imemDelay, dmemDelay, expCycles;
    logic expSel;
  } vecT;
  vecT vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic runInstr(input vecT v, input logic haltIn);
    logic hasMem;
    int memStart;
    logic [2:0] es;
    {RegWriteControl, RAMRead, RAMWriteControl} = {v.regW, v.ramR, v.ramW};
    {TestBranch, AlwaysBranch, BranchTaken, Halt} = {v.testB, v.alwaysB, v.taken, haltIn};
    hasMem = v.ramR | v.ramW;
    memStart = v.imemDelay + 3;
    for (int c = 0; c < v.expCycles; c++) begin
      es = (c <= v.imemDelay) ? 3'd0 : (c == v.imemDelay + 1) ? 3'd1 : (c == v.imemDelay + 2) ? 3'd2 :
           (hasMem && c <= memStart + v.dmemDelay) ? 3'd3 : 3'd4;
      ImemReady = (c == v.imemDelay);
      DmemReady = hasMem && (c == memStart + v.dmemDelay);
      @(negedge clk);
      check("stage", Stage, es);
      check("irload", IRLoad, es == 3'd0 && c == v.imemDelay);
      check("dmemreq", DmemReq, es == 3'd3);
      check("pcwrite", PCWriteEn, es == 3'd4);
      check("regwrite", RegWriteEn, es == 3'd4 && v.regW);
      if (es == 3'd3) check("dmemwrite", DmemWrite, v.ramW);
      if (es == 3'd4) check("pcsel", PCSelBranch, v.expSel);
      tick();
    end
    ImemReady = 0;
    DmemReady = 0;
    expRet = expRet + 4'd1;
    check("retired", InstRetired, expRet);
    check("post stage", Stage, haltIn ? 3'd5 : 3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 4, 0};   // ALU
    vecs[1] = '{1, 1, 0, 0, 0, 0, 0, 3, 8, 0};   // load, 3 wait cycles
    vecs[2] = '{0, 0, 1, 0, 0, 0, 0, 0, 5, 0};   // store
    vecs[3] = '{0, 0, 0, 1, 0, 1, 0, 0, 4, 1};   // branch taken
    vecs[4] = '{0, 0, 0, 1, 0, 0, 0, 0, 4, 0};   // branch not taken
    vecs[5] = '{0, 0, 0, 0, 1, 0, 0, 0, 4, 1};   // jump
    vecs[6] = '{1, 0, 0, 0, 0, 0, 2, 0, 6, 0};   // ALU, 2 fetch waits
    vecs[7] = '{1, 0, 0, 0, 0, 0, 15, 0, 19, 0}; // ready in 16th wait cycle
    {ImemReady, DmemReady, RegWriteControl, RAMRead, RAMWriteControl} = '0;
    {TestBranch, AlwaysBranch, BranchTaken, Halt} = '0;
    expRet = 0;
    reset = 1;
    ImemReady = 1;
    tick();
    @(negedge clk);
    check("reset imemreq", ImemReq, 0);
    check("reset irload", IRLoad, 0);
    tick();
    reset = 0;
    ImemReady = 0;
    check("reset stage", Stage, 0);
    check("reset buserror", BusError, 0);
    check("reset retired", InstRetired, 0);

    for (int i = 0; i < 8; i++) runInstr(vecs[i], 0);

    runInstr(vecs[0], 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halted", {Stage, ImemReq, PCWriteEn, DmemReq}, {3'd5, 3'b000});
      tick();
    end
    Halt = 0;
    @(negedge clk);
    check("halt release", Stage, 5);
    tick();
    check("after halt", Stage, 0);

    for (int i = 0; i < 7; i++) runInstr(vecs[0], 0);
    check("wrap zero", InstRetired, 0);

    {RegWriteControl, RAMRead, RAMWriteControl} = 3'b110;
    ImemReady = 1;
    tick();
    ImemReady = 0;
    tick();
    tick();
    @(negedge clk);
    check("mem entered", {Stage, DmemReq}, {3'd3, 1'b1});
    tick();
    reset = 1;
    @(negedge clk);
    check("reset in mem", {DmemReq, ImemReq}, 2'b00);
    tick();
    check("reset from mem", {Stage, DmemReq}, {3'd0, 1'b0});
    check("reset retired2", InstRetired, 0);
    reset = 0;
    expRet = 0;

    ImemReady = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check("fetch wait", {Stage, ImemReq}, {3'd0, 1'b1});
      tick();
    end
    check("fault entry", {Stage, BusError}, {3'd7, 1'b1});
    {ImemReady, DmemReady, RegWriteControl, AlwaysBranch, Halt} = '1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check("fault hold", {Stage, BusError, ImemReq, IRLoad, DmemReq, PCWriteEn, RegWriteEn},
            {3'd7, 1'b1, 5'b0});
      tick();
    end
    reset = 1;
    tick();
    reset = 0;
    {ImemReady, DmemReady, RegWriteControl, AlwaysBranch, Halt} = '0;
    check("fault reset", {Stage, BusError}, {3'd0, 1'b0});
    check("fault retired", InstRetired, 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter MemTimeout, default 16: maximum consecutive wait cycles allowed per memory access.
REQ-002 Parameter dataW, default 32: width of the retired-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ImemReady  input  1  instruction word valid on the instruction bus this cycle.
REQ-006 DmemReady  input  1  data memory completed the requested access this cycle.
REQ-007 RegWriteControl, RAMRead, RAMWriteControl, TestBranch, AlwaysBranch  input  1 each  decoded control flags from the instruction decoder.
REQ-008 BranchTaken  input  1  conditional branch comparison result.
REQ-009 Halt  input  1  request to stop after the current instruction retires.
REQ-010 ImemReq  output  1  instruction fetch request.
REQ-011 IRLoad  output  1  load the instruction register.
REQ-012 DmemReq  output  1  data memory access request.
REQ-013 DmemWrite  output  1  qualifies DmemReq as a write.
REQ-014 RegWriteEn  output  1  register file write strobe.
REQ-015 PCWriteEn  output  1  program counter update strobe.
REQ-016 PCSelBranch  output  1  PC takes the branch target when high and PC+4 when low.
REQ-017 Stage  output  3  current FSM state encoding.
REQ-018 BusError  output  1  sticky memory timeout flag.
REQ-019 InstRetired  output  dataW  count of retired instructions.

Function
REQ-020 States and encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALTED=5, FAULT=7; Stage shall equal the current state.
REQ-021 All outputs are Moore/registered-state decodes except IRLoad, RegWriteEn, PCSelBranch and DmemWrite, which may also depend combinationally on inputs.
REQ-022 FETCH: ImemReq=1. If ImemReady=1, IRLoad=1 that same cycle and the next state is DECODE; otherwise the FSM stays in FETCH.
REQ-023 DECODE: lasts exactly one cycle with no strobes asserted; next state is EXECUTE.
REQ-024 EXECUTE: lasts one cycle. Next state is MEM if RAMRead or RAMWriteControl is high; otherwise it is WRITEBACK.
REQ-025 MEM: DmemReq=1 and DmemWrite=RAMWriteControl. On DmemReady=1 the next state is WRITEBACK; otherwise the FSM stays in MEM.
REQ-026 WRITEBACK: lasts one cycle with PCWriteEn=1, RegWriteEn=RegWriteControl, and PCSelBranch=AlwaysBranch | (TestBranch & BranchTaken). InstRetired increments by 1 and wraps from all-ones to 0.
REQ-027 WRITEBACK exit: if Halt=1 the next state is HALTED; otherwise it is FETCH.
REQ-028 HALTED: no strobes asserted. The FSM leaves HALTED for FETCH in the first cycle Halt=0; Halt is ignored in all other states.
REQ-029 Wait counter: cleared on entry to FETCH or MEM, and increments each cycle in that state while the matching ready input is 0.
REQ-030 Timeout: if the ready input is 0 for MemTimeout consecutive cycles, the next state is FAULT. If ready arrives in the MemTimeout-th cycle, ready wins and no fault occurs.
REQ-031 FAULT: BusError=1 and all strobes are 0. FAULT is exited only by reset.
REQ-032 Minimum latency per instruction is 4 cycles without memory access and 5 cycles with memory access, with zero-wait memory.
REQ-033 Strobe exclusivity: IRLoad, DmemReq, PCWriteEn and RegWriteEn are never asserted outside their own state.

Reset
REQ-034 reset=1 at a clock edge sets state=FETCH, wait counter=0, InstRetired=0 and BusError=0 in the following cycle, from any state including MEM and FAULT.
REQ-035 While reset is high, all strobes are 0 and ImemReq is 0.

Verification
REQ-036 Zero-wait ALU instruction (RegWriteControl=1, no memory flags) -> Stage sequence 0,1,2,4,0; RegWriteEn=1 only in the Stage=4 cycle; InstRetired=1.
REQ-037 Load with DmemReady delayed 3 cycles -> MEM held for 4 cycles with DmemReq=1 and DmemWrite=0; single RegWriteEn pulse; total instruction time 8 cycles.
REQ-038 Branch with TestBranch=1 and BranchTaken=1, then BranchTaken=0 -> PCSelBranch=1 then 0 in the respective WRITEBACK cycles; RegWriteEn=0 for both.
REQ-039 ImemReady held at 0 for 16 cycles -> FAULT entered, Stage=7, BusError=1; stays in FAULT for 50 further cycles; reset returns to Stage=0 with BusError=0.
REQ-040 Boundary cases: ImemReady arriving in wait cycle 16 -> no fault; reset asserted while in MEM -> DmemReq=0 on the next cycle and Stage=0.
REQ-041 Counter and halt: InstRetired preset near all-ones retires 2 instructions and wraps to 0; Halt=1 during WRITEBACK -> Stage=5 held until Halt=0, then FETCH.
